// File: rtl/ysyx_23060236_trap_sequencer.sv
// ysyx_23060236_trap_sequencer: machine-mode trap entry / mret sequencer owning the CSR write port
// Writes mepc, mcause, mstatus one per cycle, then pulses a single fetch redirect.
module ysyx_23060236_trap_sequencer #(
    parameter logic VECTORED_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_npc,
    input  logic        exc_valid,
    input  logic [5:0]  exc_cause,
    input  logic        mret_valid,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic [31:0] mstatus_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic        inst_csr_wen,
    input  logic [11:0] inst_csr_addr,
    input  logic [31:0] inst_csr_wdata,
    output logic        inst_csr_ready,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STAT, M_STAT, REDIR} state_t;
    state_t state, next;
    logic [31:0] epc, rpc_q, base, trap_pc, target;
    logic [6:0]  cause;
    logic        is_mret, take_exc, take_mret, irq_ok, take_ext, take_tmr, event_hit, accept;
    assign take_exc  = commit_valid & exc_valid;
    assign take_mret = commit_valid & ~exc_valid & mret_valid;
    assign irq_ok    = commit_valid & ~exc_valid & ~mret_valid & mstatus_in[3];
    assign take_ext  = irq_ok & irq_ext;
    assign take_tmr  = irq_ok & ~irq_ext & irq_timer;
    assign event_hit = take_exc | take_mret | take_ext | take_tmr;
    assign accept    = (state == IDLE) & event_hit;
    assign base      = {mtvec_in[31:2], 2'b00};
    assign trap_pc   = (VECTORED_EN && mtvec_in[1:0] == 2'b01 && cause[6]) ? base + {24'b0, cause[5:0], 2'b00} : base;
    assign target    = is_mret ? mepc_in : trap_pc;
    assign commit_ready   = state == IDLE;
    assign inst_csr_ready = (state == IDLE) & ~event_hit;
    assign busy           = state != IDLE;
    assign redirect_valid = state == REDIR;
    assign redirect_pc    = redirect_valid ? target : rpc_q;
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            epc     <= '0;
            cause   <= '0;
            is_mret <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state <= next;
            if (accept) is_mret <= take_mret;
            if (accept && !take_mret) begin
                epc   <= take_exc ? commit_pc : commit_npc;
                cause <= take_exc ? {1'b0, exc_cause} : {1'b1, take_ext ? 6'd11 : 6'd7};
            end
            if (state == REDIR) rpc_q <= target;
        end
    end
    always_comb begin
        next      = state;
        csr_wen   = 1'b0;
        csr_waddr = 12'h000;
        csr_wdata = 32'h0;
        case (state)
            IDLE: begin
                csr_wen   = inst_csr_wen & ~accept;
                csr_waddr = inst_csr_addr;
                csr_wdata = inst_csr_wdata;
                next      = take_mret ? M_STAT : accept ? W_EPC : IDLE;
            end
            W_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = 12'h341;
                csr_wdata = epc;
                next      = W_CAUSE;
            end
            W_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = 12'h342;
                csr_wdata = {cause[6], 25'b0, cause[5:0]};
                next      = W_STAT;
            end
            // MPIE<=MIE, MIE<=0, MPP<=M
            W_STAT: begin
                csr_wen   = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = (mstatus_in & ~32'h0000_1888) | 32'h0000_1800 | {24'b0, mstatus_in[3], 7'b0};
                next      = REDIR;
            end
            // MIE<=MPIE, MPIE<=1, MPP<=M
            M_STAT: begin
                csr_wen   = 1'b1;
                csr_waddr = 12'h300;
                csr_wdata = (mstatus_in & ~32'h0000_1888) | 32'h0000_1880 | {28'b0, mstatus_in[7], 3'b0};
                next      = REDIR;
            end
            REDIR:   next = IDLE;
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060236_trap_sequencer.sv
// tb_ysyx_23060236_trap_sequencer: directed and random checks against a transaction-level model
module tb_ysyx_23060236_trap_sequencer;
    logic        clock = 1'b0, reset = 1'b0;
    logic        commit_valid, commit_ready, exc_valid, mret_valid, irq_ext, irq_timer;
    logic [31:0] commit_pc, commit_npc, mstatus_in, mtvec_in, mepc_in, inst_csr_wdata;
    logic [5:0]  exc_cause;
    logic        inst_csr_wen, inst_csr_ready, csr_wen, redirect_valid, busy;
    logic [11:0] inst_csr_addr, csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;
    int n_cmp = 0, n_bad = 0;
    typedef struct {
        logic        wen;
        logic [11:0] addr;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;
    exp_t q[$];
    logic [31:0] last_rpc = 32'h0;

    ysyx_23060236_trap_sequencer dut (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_npc(commit_npc), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .mret_valid(mret_valid), .irq_ext(irq_ext), .irq_timer(irq_timer), .mstatus_in(mstatus_in),
        .mtvec_in(mtvec_in), .mepc_in(mepc_in), .inst_csr_wen(inst_csr_wen), .inst_csr_addr(inst_csr_addr),
        .inst_csr_wdata(inst_csr_wdata), .inst_csr_ready(inst_csr_ready), .csr_wen(csr_wen),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic w, input logic [11:0] a, input logic [31:0] d, input logic r, input logic [31:0] p);
        exp_t e;
        e.wen = w; e.addr = a; e.data = d; e.redir = r; e.rpc = p;
        q.push_back(e);
    endtask

    // Plan the whole trap/mret transaction the moment it is accepted.
    task automatic plan();
        logic        intr;
        logic [5:0]  code;
        logic [31:0] epc, st, tgt;
        if (exc_valid) begin
            intr = 1'b0; code = exc_cause; epc = commit_pc;
        end else if (mret_valid) begin
            st = mstatus_in & ~32'h1888;
            st = st | 32'h1880 | (mstatus_in[7] ? 32'h8 : 32'h0);
            push(1'b1, 12'h300, st, 1'b0, 32'h0);
            push(1'b0, 12'h000, 32'h0, 1'b1, mepc_in);
            return;
        end else begin
            intr = 1'b1; code = irq_ext ? 6'd11 : 6'd7; epc = commit_npc;
        end
        st  = (mstatus_in & ~32'h1888) | 32'h1800 | (mstatus_in[3] ? 32'h80 : 32'h0);
        tgt = mtvec_in & ~32'h3;
        if (intr && mtvec_in[1:0] == 2'b01) tgt = tgt + 32'(code) * 4;
        push(1'b1, 12'h341, epc, 1'b0, 32'h0);
        push(1'b1, 12'h342, (intr ? 32'h8000_0000 : 32'h0) | 32'(code), 1'b0, 32'h0);
        push(1'b1, 12'h300, st, 1'b0, 32'h0);
        push(1'b0, 12'h000, 32'h0, 1'b1, tgt);
    endtask

    // Inputs are already applied; check at the falling edge, then advance one cycle.
    task automatic tick();
        logic acc;
        exp_t e;
        #4;
        if (q.size() == 0) begin
            acc = commit_valid && (exc_valid || mret_valid || (mstatus_in[3] && (irq_ext || irq_timer)));
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_commit_ready", 32'(commit_ready), 32'h1);
            check("idle_redir", 32'(redirect_valid), 32'h0);
            check("idle_rpc", redirect_pc, last_rpc);
            check("idle_inst_ready", 32'(inst_csr_ready), 32'(!acc));
            check("idle_wen", 32'(csr_wen), acc ? 32'h0 : 32'(inst_csr_wen));
            if (!acc && inst_csr_wen) begin
                check("pass_addr", 32'(csr_waddr), 32'(inst_csr_addr));
                check("pass_data", csr_wdata, inst_csr_wdata);
            end
            if (acc && reset) plan();
        end else begin
            e = q.pop_front();
            check("seq_busy", 32'(busy), 32'h1);
            check("seq_commit_ready", 32'(commit_ready), 32'h0);
            check("seq_inst_ready", 32'(inst_csr_ready), 32'h0);
            check("seq_wen", 32'(csr_wen), 32'(e.wen));
            if (e.wen) begin
                check("seq_addr", 32'(csr_waddr), 32'(e.addr));
                check("seq_data", csr_wdata, e.data);
            end
            check("seq_redir", 32'(redirect_valid), 32'(e.redir));
            check("seq_rpc", redirect_pc, e.redir ? e.rpc : last_rpc);
            if (e.redir) last_rpc = e.rpc;
        end
        if (!reset) begin
            q.delete();
            last_rpc = 32'h0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        commit_valid = 0; exc_valid = 0; mret_valid = 0; irq_ext = 0; irq_timer = 0;
        inst_csr_wen = 0; exc_cause = 0; inst_csr_addr = 0; inst_csr_wdata = 0;
    endtask

    task automatic idle_n(input int n);
        clr();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clr();
        commit_pc = 0; commit_npc = 0; mstatus_in = 0; mtvec_in = 0; mepc_in = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1;
        idle_n(2);
        check("reset_rpc", redirect_pc, 32'h0);
        // ecall
        commit_valid = 1; exc_valid = 1; exc_cause = 6'd11; commit_pc = 32'h8000_0100;
        mstatus_in = 32'h1808; mtvec_in = 32'h8000_0400;
        tick();
        idle_n(5);
        check("ecall_target", redirect_pc, 32'h8000_0400);
        // mret
        commit_valid = 1; mret_valid = 1; mstatus_in = 32'h1880; mepc_in = 32'h8000_0104;
        tick();
        idle_n(3);
        check("mret_target", redirect_pc, 32'h8000_0104);
        // vectored timer interrupt
        commit_valid = 1; irq_timer = 1; commit_npc = 32'h8000_0020; mstatus_in = 32'h1808; mtvec_in = 32'h8000_0401;
        tick();
        idle_n(5);
        check("timer_target", redirect_pc, 32'h8000_041C);
        // both irqs, MIE=0 then MIE=1
        commit_valid = 1; irq_ext = 1; irq_timer = 1; mstatus_in = 32'h0000_0080;
        tick(); tick();
        mstatus_in = 32'h0000_0008;
        tick();
        idle_n(5);
        // exception racing a timer irq, with a pending instruction CSR write
        commit_valid = 1; exc_valid = 1; exc_cause = 6'd2; irq_timer = 1; commit_pc = 32'h8000_0200;
        mstatus_in = 32'h1808; mtvec_in = 32'h8000_0401;
        inst_csr_wen = 1; inst_csr_addr = 12'h305; inst_csr_wdata = 32'h1234_5678;
        tick(); commit_valid = 0; tick(); tick(); tick(); tick();
        inst_csr_wen = 0;
        idle_n(2);
        // reset during W_CAUSE
        commit_valid = 1; exc_valid = 1; exc_cause = 6'd11;
        tick(); clr(); tick();
        reset = 0;
        tick();
        reset = 1;
        tick();
        check("rst_abandon_redir", 32'(redirect_valid), 32'h0);
        idle_n(4);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if (q.size() == 0) begin
                mstatus_in = $urandom;
                mtvec_in   = $urandom;
                mepc_in    = $urandom;
            end
            reset          = ($urandom_range(0, 99) != 0);
            commit_valid   = ($urandom_range(0, 3) != 0);
            exc_valid      = ($urandom_range(0, 4) == 0);
            exc_cause      = 6'($urandom);
            mret_valid     = ($urandom_range(0, 4) == 0);
            irq_ext        = ($urandom_range(0, 2) == 0);
            irq_timer      = ($urandom_range(0, 2) == 0);
            commit_pc      = $urandom;
            commit_npc     = $urandom;
            inst_csr_wen   = $urandom_range(0, 1) == 1;
            inst_csr_addr  = 12'($urandom);
            inst_csr_wdata = $urandom;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
